// File: rtl/core_pkg.sv
// core_pkg: shared state encoding, RV32I opcodes, decode selectors and the
// ALU control, ALU, branch-compare and immediate helpers of the multicycle core.
package core_pkg;
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
  } state_t;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_BR, ALUOP_FN} aluop_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctl_t;
  typedef enum logic [1:0] {MTR_ALU, MTR_MEM, MTR_PC4} mtr_t;
  typedef enum logic [1:0] {AL_RS1, AL_PC, AL_ZERO} auipc_lui_t;

  function automatic logic supported(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};
  endfunction

  function automatic alu_ctl_t alu_control(input aluop_t op, input logic [2:0] f3, input logic f7b5,
                                           input logic is_op);
    if (op == ALUOP_ADD) return ALU_ADD;
    if (op == ALUOP_BR) return ALU_SUB;
    case (f3)
      3'b000:  return (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_ctl_t ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ir);
    case (ir[6:0])
      OP_IMM, OP_LOAD, OP_JALR: return {{20{ir[31]}}, ir[31:20]};
      OP_STORE:                 return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:                return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         return {ir[31:12], 12'b0};
      OP_JAL:                   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                  return '0;
    endcase
  endfunction
endpackage

// File: rtl/core_fsm.sv
// core_fsm: instruction sequencer with bounded req/ack wait counter, timeout
// halt and the req/retire/sticky-flag outputs.
module core_fsm
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic [6:0] i_opcode,
  input  logic       i_imem_ack,
  input  logic       i_dmem_ack,
  output state_t     o_state,
  output logic       o_imem_req,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_retire,
  output logic       o_bus_err,
  output logic       o_illegal
);
  localparam logic [WAIT_W-1:0] LP_LAST = WAIT_W'(MAX_WAIT - 1);
  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_bus_err, r_illegal, w_req, w_ack, w_timeout, w_bad_op;
  assign w_req      = r_state == S_FETCH || r_state == S_MEM;
  assign w_ack      = r_state == S_FETCH ? i_imem_ack : i_dmem_ack;
  // an ack on the cycle the counter would reach MAX_WAIT still wins
  assign w_timeout  = w_req && !w_ack && r_wait == LP_LAST;
  assign w_bad_op   = r_state == S_DECODE && !supported(i_opcode);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = i_imem_ack ? S_DECODE : w_timeout ? S_HALT : S_FETCH;
      S_DECODE: w_next = w_bad_op ? S_HALT : S_EXEC;
      S_EXEC:   w_next = (i_opcode == OP_LOAD || i_opcode == OP_STORE) ? S_MEM : S_WB;
      S_MEM:    w_next = i_dmem_ack ? S_WB : w_timeout ? S_HALT : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= (w_req && !w_ack) ? r_wait + 1'b1 : '0;
      r_bus_err <= r_bus_err | w_timeout;
      r_illegal <= r_illegal | w_bad_op;
    end
  end
  assign o_state    = r_state;
  assign o_imem_req = RST_n && r_state == S_FETCH;
  assign o_dmem_req = r_state == S_MEM;
  assign o_dmem_we  = o_dmem_req && i_opcode == OP_STORE;
  assign o_retire   = r_state == S_WB;
  assign o_bus_err  = r_bus_err;
  assign o_illegal  = r_illegal;
endmodule

// File: rtl/core_multiciclo.sv
// core_multiciclo: multicycle RV32I core with req/ack instruction and data ports.
// Defining MULTICYCLE_PERF_EN adds the cycle_cnt/instret_cnt performance counters.
module core_multiciclo
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 8
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] PC,
  output logic [2:0]  state_o,
  output logic        retire,
  output logic        bus_err,
`ifdef MULTICYCLE_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic        illegal
);
  state_t      w_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_aluout, r_mdr;
  logic        r_taken;
  logic [31:0] r_regs [32];
  logic [6:0]  w_op;
  logic        w_reg_write, w_b_imm;
  mtr_t        w_mtr;
  aluop_t      w_aluop;
  auipc_lui_t  w_asel;
  logic [31:0] w_alu_a, w_alu_b, w_alu_res, w_pc4, w_next_pc, w_wb_data;
  core_fsm #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_fsm (
    .CLOCK(CLOCK), .RST_n(RST_n), .i_opcode(w_op), .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
    .o_state(w_state), .o_imem_req(imem_req), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_retire(retire), .o_bus_err(bus_err), .o_illegal(illegal)
  );
  assign w_op = r_ir[6:0];
  always_comb begin
    w_reg_write = 1'b1;
    w_b_imm     = 1'b1;
    w_mtr       = MTR_ALU;
    w_aluop     = ALUOP_ADD;
    w_asel      = AL_RS1;
    case (w_op)
      OP_LUI:    w_asel = AL_ZERO;
      OP_AUIPC:  w_asel = AL_PC;
      OP_JAL:    begin w_mtr = MTR_PC4; w_asel = AL_PC; end
      OP_JALR:   w_mtr = MTR_PC4;
      OP_BRANCH: begin w_reg_write = 1'b0; w_aluop = ALUOP_BR; w_b_imm = 1'b0; end
      OP_LOAD:   w_mtr = MTR_MEM;
      OP_IMM:    w_aluop = ALUOP_FN;
      OP_OP:     begin w_aluop = ALUOP_FN; w_b_imm = 1'b0; end
      default:   w_reg_write = 1'b0;
    endcase
  end
  assign w_alu_a   = w_asel == AL_PC ? r_pc : w_asel == AL_ZERO ? '0 : r_a;
  assign w_alu_b   = w_b_imm ? r_imm : r_b;
  assign w_alu_res = alu(alu_control(w_aluop, r_ir[14:12], r_ir[30], w_op == OP_OP), w_alu_a, w_alu_b);
  assign w_pc4     = r_pc + 32'd4;
  assign w_next_pc = w_op == OP_JALR ? (r_aluout & ~32'd1) :
                     (w_op == OP_JAL || r_taken) ? r_pc + r_imm : w_pc4;
  assign w_wb_data = w_mtr == MTR_MEM ? r_mdr : w_mtr == MTR_PC4 ? w_pc4 : r_aluout;
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_taken  <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (w_state)
        S_FETCH:  if (imem_ack) r_ir <= imem_rdata;
        S_DECODE: begin
          r_a   <= r_regs[r_ir[19:15]];
          r_b   <= r_regs[r_ir[24:20]];
          r_imm <= imm_gen(r_ir);
        end
        S_EXEC: begin
          r_aluout <= w_alu_res;
          r_taken  <= w_op == OP_BRANCH && br_taken(r_ir[14:12], r_a, r_b);
        end
        S_MEM:    if (dmem_ack && !dmem_we) r_mdr <= dmem_rdata;
        S_WB: begin
          if (w_reg_write && r_ir[11:7] != 5'd0) r_regs[r_ir[11:7]] <= w_wb_data;
          r_pc <= w_next_pc;
        end
        default: ;
      endcase
    end
  end
`ifdef MULTICYCLE_PERF_EN
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (w_state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif
  assign imem_addr  = r_pc;
  assign PC         = r_pc;
  assign dmem_addr  = r_aluout;
  assign dmem_wdata = r_b;
  assign state_o    = w_state;
endmodule

// File: tb/tb_core_multiciclo.sv
// tb_core_multiciclo: directed programs against req/ack memory models with
// programmable wait states; stores and retire timing expose architectural results.
module tb_core_multiciclo;
  logic        CLOCK = 1'b0, RST_n;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, bus_err, illegal;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, PC;
  logic [2:0]  state_o;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  int prog_sel, i_dly, ld_dly, st_dly, fw, dw, cyc, n_freq, n_ld, n_ld_bad;
  int ret_cyc[$];
  logic [31:0] ret_pc[$], fetch_a[$], st_a[$], st_d[$];

  core_multiciclo dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .PC(PC), .state_o(state_o),
    .retire(retire), .bus_err(bus_err),
`ifdef MULTICYCLE_PERF_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .illegal(illegal)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] prog(input int sel, input logic [31:0] a);
    if (sel == 0)
      case (a)
        32'd0:   return 32'h00500093;  // addi x1,x0,5
        32'd4:   return 32'h0000A103;  // lw   x2,0(x1)
        32'd8:   return 32'h00000863;  // beq  x0,x0,+16
        32'd24:  return 32'h002081E7;  // jalr x3,x1,2
        32'd6:   return 32'h00302023;  // sw   x3,0(x0)
        32'd10:  return 32'h00202223;  // sw   x2,4(x0)
        default: return 32'h0000000F;  // fence: unsupported
      endcase
    if (sel == 1)
      case (a)
        32'd0:   return 32'h00700293;  // addi x5,x0,7
        32'd4:   return 32'h00502423;  // sw   x5,8(x0)
        default: return 32'h0000000F;
      endcase
    return a == 32'd0 ? 32'h00502023 : 32'h0000000F;  // sw x5,0(x0)
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'd0);
    check({tag, "_pc"}, PC, 32'd0);
    check({tag, "_iaddr"}, imem_addr, 32'd0);
    check({tag, "_ireq"}, 32'(imem_req), 32'd0);
    check({tag, "_dreq"}, 32'(dmem_req), 32'd0);
    check({tag, "_retire"}, 32'(retire), 32'd0);
    check({tag, "_buserr"}, 32'(bus_err), 32'd0);
    check({tag, "_illegal"}, 32'(illegal), 32'd0);
  endtask

  task automatic do_reset(input int sel, input string tag);
    RST_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; prog_sel = sel; fw = 0; dw = 0;
    #1 reset_checks(tag);
    repeat (2) @(negedge CLOCK);
    ret_cyc.delete(); ret_pc.delete(); fetch_a.delete(); st_a.delete(); st_d.delete();
    cyc = 0; n_freq = 0; n_ld = 0; n_ld_bad = 0;
    RST_n = 1'b1;
  endtask

  task automatic step();
    #1;
    if (retire) begin ret_cyc.push_back(cyc); ret_pc.push_back(PC); end
    if (imem_req) n_freq++;
    if (dmem_req && !dmem_we) begin n_ld++; if (dmem_addr != 32'd5) n_ld_bad++; end
    imem_ack   = imem_req && fw == i_dly;
    imem_rdata = prog(prog_sel, imem_addr);
    fw         = (imem_req && !imem_ack) ? fw + 1 : 0;
    dmem_ack   = dmem_req && dw == (dmem_we ? st_dly : ld_dly);
    dw         = (dmem_req && !dmem_ack) ? dw + 1 : 0;
    if (imem_ack) fetch_a.push_back(imem_addr);
    if (dmem_ack && dmem_we) begin st_a.push_back(dmem_addr); st_d.push_back(dmem_wdata); end
    @(negedge CLOCK);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int          exp_rc[6] = '{3, 11, 15, 19, 24, 29};
    logic [31:0] exp_rp[6] = '{0, 4, 8, 24, 6, 10};
    logic [31:0] exp_fa[7] = '{0, 4, 8, 24, 6, 10, 14};
    dmem_rdata = 32'hDEADBEEF;
    i_dly = 0; ld_dly = 3; st_dly = 0;
    do_reset(0, "rst0");
    run(40);
    check("a_nretire", ret_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("a_retcyc%0d", i), ret_cyc[i], exp_rc[i]);
      check($sformatf("a_retpc%0d", i), ret_pc[i], exp_rp[i]);
    end
    check("a_nfetch", fetch_a.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("a_fetch%0d", i), fetch_a[i], exp_fa[i]);
    check("a_ld_cycles", n_ld, 4);
    check("a_ld_addr_bad", n_ld_bad, 0);
    check("a_nstore", st_a.size(), 2);
    check("a_st0_addr", st_a[0], 32'd0);
    check("a_st0_x3", st_d[0], 32'd28);
    check("a_st1_addr", st_a[1], 32'd4);
    check("a_st1_x2", st_d[1], 32'hDEADBEEF);
    check("a_state", 32'(state_o), 32'd7);
    check("a_illegal", 32'(illegal), 32'd1);
    check("a_buserr", 32'(bus_err), 32'd0);
    check("a_ireq", 32'(imem_req), 32'd0);
    check("a_pc_frozen", PC, 32'd14);
    i_dly = 14;
    do_reset(0, "rst1");
    run(20);
    check("b_nretire", ret_cyc.size(), 1);
    check("b_retcyc", ret_cyc[0], 17);
    check("b_fetch0", fetch_a[0], 32'd0);
    check("b_buserr", 32'(bus_err), 32'd0);
    i_dly = 1000;
    do_reset(0, "rst2");
    run(30);
    check("c_req_cycles", n_freq, 15);
    check("c_buserr", 32'(bus_err), 32'd1);
    check("c_state", 32'(state_o), 32'd7);
    check("c_ireq", 32'(imem_req), 32'd0);
    check("c_nretire", ret_cyc.size(), 0);
    check("c_illegal", 32'(illegal), 32'd0);
    check("c_pc", PC, 32'd0);
    i_dly = 0; st_dly = 10;
    do_reset(1, "rst3");
    run(9);
    #2;
    check("d_st_req", 32'(dmem_req && dmem_we), 32'd1);
    check("d_st_addr", dmem_addr, 32'd8);
    check("d_st_wdata", dmem_wdata, 32'd7);
    check("d_nstore", st_a.size(), 0);
    RST_n = 1'b0;
    #1 reset_checks("d_async");
    st_dly = 0;
    do_reset(2, "rst4");
    run(12);
    check("e_nstore", st_a.size(), 1);
    check("e_st_addr", st_a[0], 32'd0);
    check("e_x5_cleared", st_d[0], 32'd0);
    check("e_nretire", ret_cyc.size(), 1);
    check("e_illegal", 32'(illegal), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
